// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - common types and source encodings for the CDB arbiter
`include "const_def.sv"

package cdb_arbiter_pkg;

    typedef logic [`ROB_RANGE] rob_id_t;
    typedef logic [31:0]       data_t;

    localparam int SRC_ALU = `SRC_ALU;
    localparam int SRC_MEM = `SRC_MEM;
    localparam int SRC_AUX = `SRC_AUX;

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - result-source inputs and common data bus outputs
interface cdb_arbiter_if #(parameter int N_SRC = 3);
    import cdb_arbiter_pkg::*;

    rob_id_t [N_SRC-1:0] src_rob_id;
    data_t   [N_SRC-1:0] src_value;
    logic    [N_SRC-1:0] src_ready;
    rob_id_t             cdb_rob_id;
    data_t               cdb_value;

    modport master (
        output src_rob_id, src_value,
        input  src_ready, cdb_rob_id, cdb_value
    );

    modport slave (
        input  src_rob_id, src_value,
        output src_ready, cdb_rob_id, cdb_value
    );
endinterface

// File: rtl/cdb_src_fifo.sv
// rtl/cdb_src_fifo.sv - per-source in-order result buffer with circular pointers
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  rob_id_t       push_tag_i,
    input  data_t         push_value_i,
    input  logic          pop_i,
    output rob_id_t       head_tag_o,
    output data_t         head_value_o,
    output logic [CW-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    rob_id_t       tag_mem_q [DEPTH];
    data_t         val_mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    // Fullness is judged on the start-of-cycle count, so a same-cycle pop never frees a slot.
    assign do_push = push_i && (count_q != CNT_FULL) && !flush_i;
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            tag_mem_q[wr_ptr_q] <= push_tag_i;
            val_mem_q[wr_ptr_q] <= push_value_i;
        end
    end

    assign head_tag_o   = tag_mem_q[rd_ptr_q];
    assign head_value_o = val_mem_q[rd_ptr_q];
    assign count_o      = count_q;
endmodule

// File: rtl/const_def.sv
// rtl/const_def.sv - shared tag range and result-source index encodings
`ifndef CONST_DEF_SV
`define CONST_DEF_SV

`define ROB_RANGE 5:0
`define SRC_ALU   0
`define SRC_MEM   1
`define SRC_AUX   2

`endif

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter broadcasting buffered results onto the CDB
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_SRC      = 3,
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         flush_input,
    cdb_arbiter_if.slave bus
);
    localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [SW:0]   N_SRC_W  = (SW + 1)'(N_SRC);
    localparam logic [SW-1:0] LAST_SRC = SW'(N_SRC - 1);

    logic [N_SRC-1:0] ready, push, pop, not_empty;
    rob_id_t          head_tag   [N_SRC];
    data_t            head_value [N_SRC];
    logic [CW-1:0]    count      [N_SRC];

    logic             grant_valid;
    logic [SW-1:0]    grant_idx;
    logic [SW:0]      cand;

    logic [SW-1:0]    rr_ptr_q, rr_ptr_d;
    rob_id_t          cdb_tag_q, cdb_tag_d;
    data_t            cdb_value_q, cdb_value_d;

    for (genvar s = 0; s < N_SRC; s++) begin : g_src
        assign ready[s]     = count[s] < CW'(FIFO_DEPTH);
        assign push[s]      = (bus.src_rob_id[s] != '0) && ready[s];
        assign not_empty[s] = count[s] != '0;
        assign pop[s]       = grant_valid && (grant_idx == SW'(s)) && !flush_input;

        cdb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk_i        (clk_in),
            .rst_n_i      (rst_in),
            .flush_i      (flush_input),
            .push_i       (push[s]),
            .push_tag_i   (bus.src_rob_id[s]),
            .push_value_i (bus.src_value[s]),
            .pop_i        (pop[s]),
            .head_tag_o   (head_tag[s]),
            .head_value_o (head_value[s]),
            .count_o      (count[s])
        );
    end

    // Only buffered heads compete; a result arriving this cycle waits one edge in its FIFO.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_SRC; k++) begin
            cand = {1'b0, rr_ptr_q} + (SW + 1)'(k);
            if (cand >= N_SRC_W) cand = cand - N_SRC_W;
            if (!grant_valid && not_empty[cand[SW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[SW-1:0];
            end
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_tag_d   = '0;
        cdb_value_d = '0;
        if (flush_input) begin
            rr_ptr_d = '0;
        end else if (grant_valid) begin
            cdb_tag_d   = head_tag[grant_idx];
            cdb_value_d = head_value[grant_idx];
            rr_ptr_d    = (grant_idx == LAST_SRC) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr_q    <= '0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
        end
    end

    assign bus.src_ready  = ready;
    assign bus.cdb_rob_id = cdb_tag_q;
    assign bus.cdb_value  = cdb_value_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NS  = 3;
    localparam int DEP = 2;

    typedef rob_id_t [NS-1:0] tags_t;
    typedef data_t   [NS-1:0] vals_t;
    typedef struct packed { rob_id_t tag; data_t value; } ent_t;
    typedef struct {
        logic            fl;
        tags_t           tg;
        vals_t           vl;
        logic [NS-1:0]   rdy;
        rob_id_t         etag;
        data_t           eval;
    } vec_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic flush_input = 1'b0;

    always #5 clk_in = ~clk_in;

    cdb_arbiter_if #(.N_SRC(NS)) bus();

    cdb_arbiter #(.N_SRC(NS), .FIFO_DEPTH(DEP)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .flush_input (flush_input),
        .bus         (bus)
    );

    int   n_chk = 0;
    int   n_fail = 0;
    ent_t mq [NS][DEP];
    int   mcnt [NS];
    int   mrr = 0;
    ent_t sb [$];
    logic [63:0] seen_mask = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) mcnt[s] = 0;
        mrr = 0;
    endtask

    // Shift-register queue model: head is always slot 0.
    task automatic model_edge(input logic fl, input tags_t tg, input vals_t vl, output ent_t e);
        logic [NS-1:0] rdy;
        logic          found;
        int            s;
        for (int i = 0; i < NS; i++) rdy[i] = (mcnt[i] < DEP);
        e = '0;
        found = 1'b0;
        if (fl) begin
            model_reset();
        end else begin
            for (int k = 0; k < NS; k++) begin
                s = (mrr + k) % NS;
                if (!found && mcnt[s] > 0) begin
                    e = mq[s][0];
                    for (int j = 0; j < DEP - 1; j++) mq[s][j] = mq[s][j+1];
                    mcnt[s]--;
                    mrr = (s + 1) % NS;
                    found = 1'b1;
                end
            end
            for (int i = 0; i < NS; i++) begin
                if (tg[i] != '0) begin
                    if (rdy[i]) begin
                        mq[i][mcnt[i]] = {tg[i], vl[i]};
                        mcnt[i]++;
                    end else begin
                        $display("note: src %0d tag %0d presented while not ready, dropped", i, tg[i]);
                    end
                end
            end
        end
    endtask

    task automatic step(input logic fl, input tags_t tg, input vals_t vl,
                        input logic use_tbl, input logic [NS-1:0] t_rdy, input ent_t t_exp);
        ent_t          e;
        logic [NS-1:0] m_rdy;
        flush_input    = fl;
        bus.src_rob_id = tg;
        bus.src_value  = vl;
        for (int s = 0; s < NS; s++) m_rdy[s] = (mcnt[s] < DEP);
        #1;
        check("src_ready", 64'(bus.src_ready), 64'(use_tbl ? t_rdy : m_rdy));
        model_edge(fl, tg, vl, e);
        sb.push_back(use_tbl ? t_exp : e);
        @(posedge clk_in);
        #1;
        e = sb.pop_front();
        check("cdb_rob_id", 64'(bus.cdb_rob_id), 64'(e.tag));
        check("cdb_value", 64'(bus.cdb_value), 64'(e.value));
        if (bus.cdb_rob_id != '0) seen_mask[bus.cdb_rob_id] = 1'b1;
        flush_input    = 1'b0;
        bus.src_rob_id = '0;
        bus.src_value  = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    function automatic vec_t mk(input logic fl, input rob_id_t a, input rob_id_t m, input rob_id_t x,
                                input data_t va, input data_t vm, input data_t vx,
                                input logic [NS-1:0] rdy, input rob_id_t et, input data_t ev);
        vec_t v;
        v.fl = fl; v.tg = {x, m, a}; v.vl = {vx, vm, va};
        v.rdy = rdy; v.etag = et; v.eval = ev;
        return v;
    endfunction

    vec_t tbl [17];

    initial begin
        tags_t tg;
        vals_t vl;
        int    gcnt [NS];
        int    last [NS];
        int    maxgap [NS];
        int    ntag [NS];
        int    src;

        tbl[0]  = mk(0, 5,  0,  0, 32'h11, 0,     0,     3'b111, 0,  0);
        tbl[1]  = mk(0, 0,  0,  0, 0,     0,     0,     3'b111, 5,  32'h11);
        tbl[2]  = mk(0, 0,  0,  0, 0,     0,     0,     3'b111, 0,  0);
        tbl[3]  = mk(0, 1,  20, 0, 32'h01, 32'h20, 0,    3'b111, 0,  0);
        tbl[4]  = mk(0, 2,  21, 0, 32'h02, 32'h21, 0,    3'b111, 20, 32'h20);
        tbl[5]  = mk(0, 30, 0,  0, 32'h30, 0,     0,     3'b110, 1,  32'h01);
        tbl[6]  = mk(0, 0,  0,  0, 0,     0,     0,     3'b111, 21, 32'h21);
        tbl[7]  = mk(0, 0,  0,  0, 0,     0,     0,     3'b111, 2,  32'h02);
        tbl[8]  = mk(0, 0,  0,  0, 0,     0,     0,     3'b111, 0,  0);
        tbl[9]  = mk(0, 0,  0,  9, 0,     0,     32'h99, 3'b111, 0,  0);
        tbl[10] = mk(0, 0,  0,  0, 0,     0,     0,     3'b111, 9,  32'h99);
        tbl[11] = mk(0, 0,  0,  0, 0,     0,     0,     3'b111, 0,  0);
        tbl[12] = mk(0, 3,  4,  6, 32'h33, 32'h44, 32'h66, 3'b111, 0, 0);
        tbl[13] = mk(0, 0,  0,  0, 0,     0,     0,     3'b111, 3,  32'h33);
        tbl[14] = mk(0, 0,  0,  0, 0,     0,     0,     3'b111, 4,  32'h44);
        tbl[15] = mk(0, 0,  0,  0, 0,     0,     0,     3'b111, 6,  32'h66);
        tbl[16] = mk(0, 0,  0,  0, 0,     0,     0,     3'b111, 0,  0);

        bus.src_rob_id = '0;
        bus.src_value  = '0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        check("reset_cdb_rob_id", 64'(bus.cdb_rob_id), 64'd0);
        check("reset_cdb_value", 64'(bus.cdb_value), 64'd0);
        check("reset_src_ready", 64'(bus.src_ready), 64'b111);
        rst_in = 1'b1;

        // Directed table: single result, back-pressure, skip of empty sources, contention.
        for (int i = 0; i < 17; i++)
            step(tbl[i].fl, tbl[i].tg, tbl[i].vl, 1'b1, tbl[i].rdy, {tbl[i].etag, tbl[i].eval});
        check("overfull_tag_dropped", 64'(seen_mask[30]), 64'd0);

        // Fairness under continuous supply from all sources.
        for (int s = 0; s < NS; s++) begin
            gcnt[s] = 0; last[s] = 0; maxgap[s] = 0; ntag[s] = 0;
        end
        for (int i = 0; i <= 30; i++) begin
            for (int s = 0; s < NS; s++) begin
                if (mcnt[s] < DEP) begin
                    ntag[s]++;
                    tg[s] = 6'(1 + ntag[s] % 60);
                    vl[s] = {2'(s), 30'(i)};
                end else begin
                    tg[s] = '0;
                    vl[s] = '0;
                end
            end
            step(1'b0, tg, vl, 1'b0, '0, '0);
            if (bus.cdb_rob_id != '0) begin
                src = int'(bus.cdb_value[31:30]);
                if (src < NS) begin
                    gcnt[src]++;
                    if (i - last[src] > maxgap[src]) maxgap[src] = i - last[src];
                    last[src] = i;
                end
            end
        end
        for (int s = 0; s < NS; s++) begin
            check($sformatf("fair_grants_src%0d", s), 64'(gcnt[s]), 64'd10);
            check($sformatf("fair_wait_src%0d", s), 64'(maxgap[s] > 3), 64'd0);
        end
        idle(6);

        // Flush with five entries buffered and a concurrent MEM push.
        step(1'b1, '0, '0, 1'b0, '0, '0);
        step(1'b0, {6'd0, 6'd0, 6'd10}, {32'd0, 32'd0, 32'h100}, 1'b0, '0, '0);
        idle(1);
        step(1'b0, {6'd13, 6'd12, 6'd11}, {32'h113, 32'h112, 32'h111}, 1'b0, '0, '0);
        step(1'b0, {6'd16, 6'd15, 6'd14}, {32'h116, 32'h115, 32'h114}, 1'b0, '0, '0);
        seen_mask = '0;
        step(1'b1, {6'd0, 6'd7, 6'd0}, {32'd0, 32'h107, 32'd0}, 1'b0, '0, '0);
        check("flush_src_ready", 64'(bus.src_ready), 64'b111);
        idle(5);
        check("flush_tag7_never", 64'(seen_mask[7]), 64'd0);
        check("flush_no_stale", 64'(seen_mask[16:11]), 64'd0);

        // Asynchronous reset between edges with entries buffered.
        step(1'b0, {6'd23, 6'd22, 6'd21}, {32'h123, 32'h122, 32'h121}, 1'b0, '0, '0);
        step(1'b0, {6'd26, 6'd25, 6'd24}, {32'h126, 32'h125, 32'h124}, 1'b0, '0, '0);
        #4;
        rst_in = 1'b0;
        #1;
        check("async_reset_cdb_rob_id", 64'(bus.cdb_rob_id), 64'd0);
        check("async_reset_cdb_value", 64'(bus.cdb_value), 64'd0);
        check("async_reset_src_ready", 64'(bus.src_ready), 64'b111);
        #1;
        rst_in = 1'b1;
        model_reset();
        seen_mask = '0;
        idle(5);
        check("reset_no_stale", 64'(seen_mask[26:21]), 64'd0);

        // Randomised traffic against the queue model.
        for (int i = 0; i < 150; i++) begin
            for (int s = 0; s < NS; s++) begin
                if (mcnt[s] < DEP && $urandom_range(1, 0) == 1) begin
                    tg[s] = 6'($urandom_range(63, 1));
                    vl[s] = $urandom;
                end else begin
                    tg[s] = '0;
                    vl[s] = '0;
                end
            end
            step($urandom_range(24, 0) == 0, tg, vl, 1'b0, '0, '0);
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
